// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
package pll_ctrl_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } pll_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset and lock sequencer: holds areset, waits for stable lock, publishes clk_ready,
// retries on timeout, latches a fault after too many attempts and counts lock losses.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  pll_locked,
  input  logic                  restart,
  output logic                  pll_areset,
  output logic                  clk_ready,
  output logic                  fault,
  output logic [STATE_W-1:0]    state,
  output logic [2:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int unsigned MaxCycles = max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned TimerW    = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] RstLast     = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        RetryLimit  = 3'(MAX_RETRY);

  logic                  locked_s;
  pll_state_e            state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [2:0]            retry_q, retry_d, retry_inc;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  areset_q, ready_q, fault_q;

  sync_2ff u_locked_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  assign retry_inc = retry_q + 3'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = StResetPll;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
            timer_d = '0;
          end else if (timer_q == TimeoutLast) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RetryLimit) ? StFault : StResetPll;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StStable: begin
          if (!locked_s) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == StableLast) begin
            state_d = StRun;
            retry_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StRun: begin
          if (!locked_s) begin
            if (loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
            state_d = StResetPll;
            timer_d = '0;
          end
        end
        StFault: ;
        default: begin
          state_d = StResetPll;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state_q.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StResetPll;
      timer_q  <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      areset_q <= 1'b1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      areset_q <= (state_d == StResetPll) || (state_d == StFault);
      ready_q  <= (state_d == StRun);
      fault_q  <= (state_d == StFault);
    end
  end

  assign pll_areset    = areset_q;
  assign clk_ready     = ready_q;
  assign fault         = fault_q;
  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule
